// File: rtl/fsm_flip_flop.sv
// fsm_flip_flop: single-bit D flip-flop built as a two-state Moore FSM.
// The reset is asynchronous and active-low, and it loads RESET_VALUE.
module fsm_flip_flop #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic D,
   output logic Q,
   output logic nQ
);
   typedef enum logic {S0 = 1'b0, S1 = 1'b1} state_t;
   localparam state_t RST_STATE = RESET_VALUE ? S1 : S0;
   state_t r_state, w_next;
   // An unknown D merges both arms into an unknown next state; reset clears it
   always_comb w_next = D ? S1 : S0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= RST_STATE;
      else r_state <= w_next;
   always_comb begin
      Q  = (r_state == S1);
      nQ = ~Q;
   end
endmodule

// File: tb/tb_fsm_flip_flop.sv
// tb_fsm_flip_flop: directed and random checks of fsm_flip_flop against a
// history-of-samples model: Q must equal the last D captured since reset.
module tb_fsm_flip_flop;
   logic clk = 1'b0, clk_en = 1'b0, rst_n = 1'b1, D = 1'b0, Q, nQ;
   logic run_cmp = 1'b0;
   int   errors = 0, checks = 0;
   logic hist[$];

   fsm_flip_flop #(.RESET_VALUE(1'b0)) dut (.clk(clk), .rst_n(rst_n), .D(D), .Q(Q), .nQ(nQ));

   initial forever #5 clk = clk_en ? ~clk : clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_q();
      return (hist.size() == 0) ? 1'b0 : hist[$];
   endfunction

   always @(negedge rst_n) hist.delete();
   always @(posedge clk) if (rst_n) hist.push_back(D);

   always @(posedge clk) begin
      #1;
      if (run_cmp) begin
         chk("cycle_q", Q, model_q());
         chk("cycle_nq", nQ, ~Q);
      end
   end

   initial begin
      // 1: reset with clock idle acts immediately, release keeps state
      D = 1'b1;
      #3 rst_n = 1'b0;
      #1 chk("reset_q", Q, 1'b0);
      chk("reset_nq", nQ, 1'b1);
      #5 rst_n = 1'b1;
      #1 chk("release_q", Q, 1'b0);
      chk("release_nq", nQ, 1'b1);
      // 2: capture D=0
      D = 1'b0;
      run_cmp = 1'b1;
      clk_en = 1'b1;
      @(posedge clk); #1;
      chk("d0_q", Q, 1'b0);
      chk("d0_nq", nQ, 1'b1);
      // 3: D rises while clk high, no effect until next posedge
      #1 D = 1'b1;
      #1 chk("mid_hi_q", Q, 1'b0);
      @(posedge clk); #1;
      chk("d1_q", Q, 1'b1);
      chk("d1_nq", nQ, 1'b0);
      // 4: D falls while clk high, falling edge does not capture
      #1 D = 1'b0;
      @(negedge clk); #1;
      chk("negedge_q", Q, 1'b1);
      @(posedge clk); #1;
      chk("d0b_q", Q, 1'b0);
      chk("d0b_nq", nQ, 1'b1);
      // 5: async reset mid-cycle, then reset wins over a posedge with D=1
      D = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst_q", Q, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("async_q", Q, 1'b0);
      chk("async_nq", nQ, 1'b1);
      @(posedge clk); #1;
      chk("rst_edge_q", Q, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_q", Q, 1'b1);
      // 6: random D, checked by the per-cycle compare
      repeat (200) begin
         @(negedge clk);
         D = 1'($urandom);
      end
      @(posedge clk); #2;
      run_cmp = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
